// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state codes
// (3-bit, legacy-compatible encoding) and the running-checksum helper.
package imem_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t LEN_HI  = 3'd0;
    localparam state_t LEN_LO  = 3'd1;
    localparam state_t DATA_HI = 3'd2;
    localparam state_t DATA_LO = 3'd3;
    localparam state_t CHK     = 3'd4;
    localparam state_t DONE    = 3'd5;
    localparam state_t ERROR   = 3'd6;

    // Checksum is a plain modulo-256 byte sum.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream ingress (valid/ready) plus the instruction-memory write port.
// master = stream source / memory side, slave = the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte image into instruction memory as 16-bit words.
// Write lands one cycle after the low byte is accepted; stalls only via in_valid, never toward memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    imem_loader_if.slave  bus,
    output logic          cpu_rst_n,
    output logic          done,
    output logic          err
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t            state;
    logic [7:0]        sum;
    logic [15:0]       count;
    logic [15:0]       len;
    logic [7:0]        len_hi;
    logic [7:0]        hi_byte;
    logic              rdy_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              xfer;
    logic              terminal;
    logic [15:0]       n_len;

    assign terminal = (state == DONE) || (state == ERROR);
    // rdy_q keeps in_ready low for the first cycle out of reset.
    assign bus.in_ready = rdy_q && Rst && !terminal;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign n_len        = {len_hi, bus.in_data};

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign done      = (state == DONE);
    assign err       = (state == ERROR);
    assign cpu_rst_n = (state == DONE);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= LEN_HI;
            sum     <= 8'd0;
            count   <= 16'd0;
            len     <= 16'd0;
            len_hi  <= 8'd0;
            hi_byte <= 8'd0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'd0;
        end else begin
            rdy_q <= 1'b1;
            we_q  <= 1'b0;
            // Address advances after the write cycle, wrapping naturally at DEPTH.
            if (we_q) begin
                addr_q <= addr_q + 1'b1;
            end
            if (xfer) begin
                if (state != CHK) begin
                    sum <= sum8(sum, bus.in_data);
                end
                case (state)
                    LEN_HI: begin
                        len_hi <= bus.in_data;
                        state  <= LEN_LO;
                    end
                    LEN_LO: begin
                        len <= n_len;
                        if (n_len == 16'd0) begin
                            state <= CHK;
                        end else if ({1'b0, n_len} > DEPTH) begin
                            state <= ERROR;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                    DATA_HI: begin
                        hi_byte <= bus.in_data;
                        state   <= DATA_LO;
                    end
                    DATA_LO: begin
                        we_q    <= 1'b1;
                        wdata_q <= {hi_byte, bus.in_data};
                        count   <= count + 16'd1;
                        state   <= (count + 16'd1 == len) ? CHK : DATA_HI;
                    end
                    CHK: begin
                        state <= (bus.in_data == sum) ? DONE : ERROR;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frame vectors plus hand-written
// mid-load reset and idle-hold sequences; memory writes checked via a scoreboard queue.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic Clk;
    logic Rst;
    logic cpu_rst_n;
    logic done;
    logic err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .bus       (bus_if),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic prev_we = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [23:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected {addr, data}.
    always @(negedge Clk) begin
        if (bus_if.mem_we === 1'b1) begin
            logic [23:0] e;
            we_cnt++;
            if (prev_we) chk("we_pulse_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                chk("spurious_write", {8'd0, bus_if.mem_addr, bus_if.mem_wdata}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr_data", {8'd0, bus_if.mem_addr, bus_if.mem_wdata}, {8'd0, e});
            end
        end
        prev_we = bus_if.mem_we;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        bus_if.in_valid = 1'b0;
        tick();
        chk("rst_in_ready", bus_if.in_ready, 0);
        chk("rst_mem_we", bus_if.mem_we, 0);
        chk("rst_mem_addr", bus_if.mem_addr, 0);
        chk("rst_mem_wdata", bus_if.mem_wdata, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_done_err", {done, err}, 0);
        Rst = 1'b1;
        chk("rst_ready_first_cycle", bus_if.in_ready, 0);
        tick();
        chk("rst_ready_after", bus_if.in_ready, 1);
        exp_addr = '0;
        we_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        int g;
        g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        repeat (g) tick();
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = b;
        t = 0;
        while (!bus_if.in_ready && t < 20) begin
            tick();
            t++;
        end
        if (!bus_if.in_ready) chk("ready_timeout", bus_if.in_ready, 1);
        else tick();
        bus_if.in_valid = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit fixed_w, input bit bad_chk,
                             input bit hdr_only, input int gap);
        logic [15:0] nn;
        logic [15:0] w;
        logic [7:0]  s;
        nn = n[15:0];
        s  = 8'd0;
        send_byte(nn[15:8], gap); s = s + nn[15:8];
        send_byte(nn[7:0], gap);  s = s + nn[7:0];
        if (!hdr_only) begin
            for (int i = 0; i < n; i++) begin
                if (fixed_w) w = (i == 0) ? 16'h1234 : 16'hABCD;
                else         w = 16'($urandom);
                exp_q.push_back({exp_addr, w});
                exp_addr = exp_addr + 1'b1;
                send_byte(w[15:8], gap); s = s + w[15:8];
                send_byte(w[7:0], gap);  s = s + w[7:0];
            end
            send_byte(bad_chk ? s + 8'd1 : s, gap);
        end
    endtask

    typedef struct {
        string name;
        int    n;
        bit    fixed_w;
        bit    bad_chk;
        bit    hdr_only;
        int    gap;
        bit    exp_done;
        int    exp_writes;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'd0;

        vecs[0] = '{"two_words",   2,   1'b1, 1'b0, 1'b0, 0, 1'b1, 2};
        vecs[1] = '{"bad_chk",     2,   1'b1, 1'b1, 1'b0, 0, 1'b0, 2};
        vecs[2] = '{"empty",       0,   1'b1, 1'b0, 1'b0, 0, 1'b1, 0};
        vecs[3] = '{"too_long",    257, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0};
        vecs[4] = '{"gaps",        2,   1'b1, 1'b0, 1'b0, 3, 1'b1, 2};
        vecs[5] = '{"full_depth",  256, 1'b0, 1'b0, 1'b0, 0, 1'b1, 256};
        vecs[6] = '{"rand_gaps",   5,   1'b0, 1'b0, 1'b0, 2, 1'b1, 5};

        for (int i = 0; i < NV; i++) begin
            do_reset();
            run_frame(vecs[i].n, vecs[i].fixed_w, vecs[i].bad_chk, vecs[i].hdr_only, vecs[i].gap);
            chk({vecs[i].name, "_done"}, done, vecs[i].exp_done);
            chk({vecs[i].name, "_err"}, err, !vecs[i].exp_done);
            chk({vecs[i].name, "_cpu_rst_n"}, cpu_rst_n, vecs[i].exp_done);
            repeat (3) tick();
            chk({vecs[i].name, "_ready_terminal"}, bus_if.in_ready, 0);
            chk({vecs[i].name, "_sticky"}, {done, err}, {vecs[i].exp_done, !vecs[i].exp_done});
            chk({vecs[i].name, "_writes"}, we_cnt, vecs[i].exp_writes);
            chk({vecs[i].name, "_addr"}, bus_if.mem_addr, exp_addr);
            chk({vecs[i].name, "_sb_empty"}, exp_q.size(), 0);
        end

        // Reset after the first data word, then resend the full two-word image.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        exp_q.push_back({8'h00, 16'h1234});
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        do_reset();
        chk("midrst_sb_empty", exp_q.size(), 0);
        run_frame(2, 1'b1, 1'b0, 1'b0, 0);
        tick();
        chk("midrst_done", {done, err, cpu_rst_n}, 3'b101);
        chk("midrst_writes", we_cnt, 2);
        chk("midrst_sb_drained", exp_q.size(), 0);

        // Idle cycles mid-word must hold state and produce no write.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        repeat (10) tick();
        chk("idle_no_write", we_cnt, 0);
        chk("idle_ready", bus_if.in_ready, 1);
        chk("idle_not_done", {done, err}, 0);
        exp_q.push_back({8'h00, 16'h1277});
        send_byte(8'h77, 0);
        send_byte(8'h8A, 0);
        tick();
        chk("idle_done", {done, err}, 2'b10);
        chk("idle_writes", we_cnt, 1);
        chk("idle_addr", bus_if.mem_addr, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
